// File: rtl/mac_accumulator.sv
// Burst multiply-accumulate back end: sums LEN signed products from the array
// multiplier and hands out one saturated result per burst over valid/ready.
module mac_accumulator #(
    parameter int PROD_W = 64,
    parameter int GUARD  = 8,
    parameter int OUT_W  = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic              busy,
    output logic [CNT_W-1:0]  count
);

    localparam int ACC_W = PROD_W + GUARD;
    localparam int TOP_W = ACC_W - OUT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t            state_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  remaining_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [OUT_W-1:0]  data_reg;
    logic              sat_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              busy_reg;
    logic              beat;
    logic [TOP_W-1:0]  acc_top;
    logic [OUT_W-1:0]  sat_data;
    logic              sat_flag;

    assign beat = in_valid & in_ready_reg;

    // Bits above the output sign position must all match the sign for the
    // sum to fit; otherwise clamp toward the sign of the full accumulator.
    always_comb begin
        acc_next = acc_reg + {{GUARD{in_prod[PROD_W-1]}}, in_prod};
        acc_top  = acc_next[ACC_W-1:OUT_W-1];
        sat_flag = 1'b0;
        sat_data = acc_next[OUT_W-1:0];
        if (!((&acc_top) || (~|acc_top))) begin
            sat_flag = 1'b1;
            if (acc_next[ACC_W-1])
                sat_data = {1'b1, {(OUT_W-1){1'b0}}};
            else
                sat_data = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            remaining_reg <= '0;
            count_reg     <= '0;
            data_reg      <= '0;
            sat_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        acc_reg   <= '0;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        if (len != '0) begin
                            remaining_reg <= len;
                            in_ready_reg  <= 1'b1;
                            state_reg     <= S_ACC;
                        end else begin
                            data_reg      <= '0;
                            sat_reg       <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= S_OUT;
                        end
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        acc_reg       <= acc_next;
                        count_reg     <= count_reg + CNT_W'(1);
                        remaining_reg <= remaining_reg - CNT_W'(1);
                        // Final beat: capture the clamped sum directly so the
                        // result is valid one cycle after the last product.
                        if (remaining_reg == CNT_W'(1)) begin
                            data_reg      <= sat_data;
                            sat_reg       <= sat_flag;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = data_reg;
    assign out_sat   = sat_reg;
    assign busy      = busy_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: stimulus pushes expected results into a
// scoreboard queue, an independent monitor pops them on each output handshake.
module tb_mac_accumulator;

    localparam int PROD_W = 64;
    localparam int OUT_W  = 64;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sat;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic              busy;
    logic [CNT_W-1:0]  count;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [63:0] pv [8];

    mac_accumulator #(.PROD_W(PROD_W), .GUARD(8), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn: out_data=%h out_sat=%0b count=%0d", out_data, out_sat, count);
                check("out_data", out_data, e.data);
                check("out_sat", {63'd0, out_sat}, {63'd0, e.sat});
                check("count", {48'd0, count}, {48'd0, e.cnt});
            end
        end
    end

    // Wait (bounded) for the result to be consumed and the block to idle.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("return_to_idle", {63'd0, busy}, 64'd0);
        check("out_valid_low_idle", {63'd0, out_valid}, 64'd0);
    endtask

    // Runs a burst of n products from pv with gap idle cycles between beats;
    // hold > 0 stalls out_ready and pulses start while the result is pending.
    task automatic run_burst(input int n, input int gap, input int hold,
                             input logic [63:0] exp_d, input logic exp_s);
        exp_t e;
        e.data = exp_d;
        e.sat  = exp_s;
        e.cnt  = CNT_W'(n);
        exp_q.push_back(e);
        out_ready = (hold == 0);
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("in_ready_acc", {63'd0, in_ready}, 64'd1);
            check("no_early_valid", {63'd0, out_valid}, 64'd0);
            in_valid = 1'b1;
            in_prod  = pv[i];
            tick();
            in_valid = 1'b0;
            in_prod  = '0;
            if (i != n - 1)
                for (int g = 0; g < gap; g++) tick();
        end
        check("latency_out_valid", {63'd0, out_valid}, 64'd1);
        check("count_final", {48'd0, count}, n);
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            len   = 16'd7;
            check("hold_data", out_data, exp_d);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (hold > 0) begin
            tick();
            check("single_handshake", {63'd0, out_valid}, 64'd0);
            tick();
            check("start_ignored", {63'd0, busy}, 64'd0);
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_prod = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_count", {48'd0, count}, 64'd0);
        check("rst_data", out_data, 64'd0);
        rst_n = 1'b1;
        tick();

        // T1: mixed-sign sum, no gaps
        pv[0] = 64'd16;
        pv[1] = -64'sd40;
        pv[2] = 64'd90;
        pv[3] = -64'sd4128537378816;
        run_burst(4, 0, 0, -64'sd4128537378750, 1'b0);

        // T2: positive overflow clamps
        pv[0] = 64'h7FFF_FFFF_FFFF_FFFF;
        pv[1] = 64'h7FFF_FFFF_FFFF_FFFF;
        run_burst(2, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);

        // T3: negative overflow clamps
        pv[0] = 64'h8000_0000_0000_0000;
        pv[1] = 64'h8000_0000_0000_0000;
        run_burst(2, 0, 0, 64'h8000_0000_0000_0000, 1'b1);

        // T4: gaps on input, stalled output with start pulses
        pv[0] = 64'd5;
        pv[1] = -64'sd7;
        pv[2] = 64'd100;
        run_burst(3, 2, 5, 64'd98, 1'b0);

        // T5: zero-length burst
        begin
            exp_t e;
            e.data = '0; e.sat = 1'b0; e.cnt = '0;
            exp_q.push_back(e);
            start = 1'b1; len = '0;
            tick();
            start = 1'b0;
            check("len0_valid", {63'd0, out_valid}, 64'd1);
            check("len0_count", {48'd0, count}, 64'd0);
            wait_idle();
        end

        // T6: reset after first beat discards the burst
        start = 1'b1; len = 16'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 64'd1234;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_count", {48'd0, count}, 64'd0);
        check("abort_data", out_data, 64'd0);
        tick(); tick();
        check("abort_no_output", {63'd0, out_valid}, 64'd0);
        pv[0] = 64'd90;
        run_burst(1, 0, 0, 64'd90, 1'b0);

        tick();
        check("scoreboard_empty", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
